sync_fifo_param: RTL and testbench

Single-clock, fully parametrised FIFO with the same error/flag semantics as the team's async FIFO. Adds configurable depth, almost-full/almost-empty thresholds, fill count and a selectable first-word-fall-through (FWFT) read mode. It is intended as the standard buffering stage between same-clock producers and consumers in the UVM project DUTs.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo_param.sv | 124 ++++++++++++
 tb/tb_sync_fifo_param.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared defaults and width helpers for the synchronous FIFO family.
// Revision : 1.1
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Occupancy needs to represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array, synchronous write, asynchronous read.
`default_nettype none

module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered flags, error pulses and optional FWFT output.
`default_nettype none

module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_en_i,
  input  logic [WIDTH-1:0]          wdata_i,
  input  logic                      rd_en_i,
  output logic [WIDTH-1:0]          rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      almost_full_o,
  output logic                      almost_empty_o,
  output logic                      wr_error_o,
  output logic                      rd_error_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic             wr_acc;
  logic             rd_acc;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [PW-1:0]    mem_raddr;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] mem_rdata;

  always_comb begin
    wr_acc     = wr_en_i && !full_o;
    rd_acc     = rd_en_i && !empty_o;

    wr_ptr_nxt = wr_ptr;
    if (wr_acc) wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);

    rd_ptr_nxt = rd_ptr;
    if (rd_acc) rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);

    count_nxt  = count_o;
    if (wr_acc && !rd_acc)      count_nxt = count_o + CW'(1);
    else if (rd_acc && !wr_acc) count_nxt = count_o - CW'(1);
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clk_i),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wdata_i),
    .rd_addr (mem_raddr),
    .rd_data (mem_rdata)
  );

  // Flags come from the next count so they line up with count_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_o        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      wr_error_o     <= 1'b0;
      rd_error_o     <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      count_o        <= count_nxt;
      full_o         <= (count_nxt == DEPTH_C);
      empty_o        <= (count_nxt == '0);
      almost_full_o  <= (count_nxt >= AF_C);
      almost_empty_o <= (count_nxt <= AE_C);
      wr_error_o     <= wr_en_i && full_o;
      rd_error_o     <= rd_en_i && empty_o;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic head_from_write;

      // The read port looks ahead to the post-edge head. When that head is the
      // word being written this edge, it is not in the array yet, so take wdata_i.
      assign mem_raddr       = rd_ptr_nxt;
      assign head_from_write = wr_acc && (count_o == (rd_acc ? CW'(1) : CW'(0)));

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                  rdata_o <= '0;
        else if (count_nxt != '0)   rdata_o <= head_from_write ? wdata_i : mem_rdata;
      end
    end else begin : g_std
      assign mem_raddr = rd_ptr;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       rdata_o <= '0;
        else if (rd_acc) rdata_o <= mem_rdata;
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: queue-model scoreboard for a depth-8 standard FIFO and a depth-5 FWFT FIFO.
`default_nettype none

module tb_sync_fifo_param;

  typedef struct {
    logic [7:0] rdata;
    int         count;
    bit         full;
    bit         empty;
    bit         af;
    bit         ae;
    bit         werr;
    bit         rerr;
  } exp_t;

  localparam int DEP [2] = '{8, 5};
  localparam int AFT [2] = '{6, 4};
  localparam int AET [2] = '{1, 1};
  localparam int FW  [2] = '{0, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we_a = 1'b0, re_a = 1'b0, we_b = 1'b0, re_b = 1'b0;
  logic [7:0] wd_a = '0, wd_b = '0;

  logic [7:0] a_rdata, b_rdata;
  logic       a_full, a_empty, a_af, a_ae, a_werr, a_rerr;
  logic       b_full, b_empty, b_af, b_ae, b_werr, b_rerr;
  logic [3:0] a_count;
  logic [2:0] b_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] mq  [2][$];
  exp_t       eq  [2][$];
  logic [7:0] mrd [2];

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) u_a (
    .clk_i(clk), .rst_i(rst), .wr_en_i(we_a), .wdata_i(wd_a), .rd_en_i(re_a),
    .rdata_o(a_rdata), .full_o(a_full), .empty_o(a_empty), .almost_full_o(a_af),
    .almost_empty_o(a_ae), .wr_error_o(a_werr), .rd_error_o(a_rerr), .count_o(a_count)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)) u_b (
    .clk_i(clk), .rst_i(rst), .wr_en_i(we_b), .wdata_i(wd_b), .rd_en_i(re_b),
    .rdata_o(b_rdata), .full_o(b_full), .empty_o(b_empty), .almost_full_o(b_af),
    .almost_empty_o(b_ae), .wr_error_o(b_werr), .rd_error_o(b_rerr), .count_o(b_count)
  );

  function automatic exp_t act(input int d);
    exp_t a;
    if (d == 0) begin
      a.rdata = a_rdata; a.count = int'(a_count); a.full = a_full; a.empty = a_empty;
      a.af = a_af; a.ae = a_ae; a.werr = a_werr; a.rerr = a_rerr;
    end else begin
      a.rdata = b_rdata; a.count = int'(b_count); a.full = b_full; a.empty = b_empty;
      a.af = b_af; a.ae = b_ae; a.werr = b_werr; a.rerr = b_rerr;
    end
    return a;
  endfunction

  task automatic chk(input int d, input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h at %0t", d, name, got, want, $time);
    end
  endtask

  task automatic cmp(input int d, input exp_t a, input exp_t e);
    chk(d, "rdata", int'(a.rdata), int'(e.rdata));
    chk(d, "count", a.count, e.count);
    chk(d, "full", int'(a.full), int'(e.full));
    chk(d, "empty", int'(a.empty), int'(e.empty));
    chk(d, "almost_full", int'(a.af), int'(e.af));
    chk(d, "almost_empty", int'(a.ae), int'(e.ae));
    chk(d, "wr_error", int'(a.werr), int'(e.werr));
    chk(d, "rd_error", int'(a.rerr), int'(e.rerr));
  endtask

  // Reference: a FIFO is a queue; flags and errors follow from its size before/after the edge.
  task automatic model(input int d, input bit w, input logic [7:0] dat, input bit r, output exp_t e);
    bit         was_full, was_empty;
    logic [7:0] v;
    was_full  = (mq[d].size() == DEP[d]);
    was_empty = (mq[d].size() == 0);
    if (r && !was_empty) begin
      v = mq[d].pop_front();
      if (FW[d] == 0) mrd[d] = v;
    end
    if (w && !was_full) mq[d].push_back(dat);
    if (FW[d] != 0 && mq[d].size() > 0) mrd[d] = mq[d][0];
    e.rdata = mrd[d];
    e.count = mq[d].size();
    e.full  = (e.count == DEP[d]);
    e.empty = (e.count == 0);
    e.af    = (e.count >= AFT[d]);
    e.ae    = (e.count <= AET[d]);
    e.werr  = w && was_full;
    e.rerr  = r && was_empty;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      eq[d].delete();
      mrd[d] = '0;
    end
  endtask

  task automatic step(input int d, input bit w, input logic [7:0] dat, input bit r);
    exp_t e0, e1;
    we_a = (d == 0) && w; wd_a = (d == 0) ? dat : 8'($urandom); re_a = (d == 0) && r;
    we_b = (d == 1) && w; wd_b = (d == 1) ? dat : 8'($urandom); re_b = (d == 1) && r;
    model(0, we_a, wd_a, re_a, e0);
    model(1, we_b, wd_b, re_b, e1);
    @(posedge clk);
    eq[0].push_back(e0);
    eq[1].push_back(e1);
    #1;
  endtask

  task automatic chk_reset(input int d);
    exp_t r;
    r.rdata = '0; r.count = 0; r.full = 0; r.empty = 1; r.af = 0; r.ae = 1; r.werr = 0; r.rerr = 0;
    cmp(d, act(d), r);
  endtask

  task automatic rand_run(input int d, input int n);
    int pw;
    for (int i = 0; i < n; i++) begin
      pw = ((i / 25) % 2 == 0) ? 75 : 25;
      step(d, ($urandom_range(0, 99) < pw), 8'($urandom), ($urandom_range(0, 99) < (100 - pw)));
    end
  endtask

  // Monitor: every cycle both DUTs present a registered result; compare it to the queued expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (eq[d].size() > 0) begin
        mon_e = eq[d].pop_front();
        cmp(d, act(d), mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);

    // Fill / overflow / full wr+rd / drain / underflow on the standard FIFO.
    for (int i = 1; i <= 8; i++) step(0, 1'b1, 8'(i), 1'b0);
    step(0, 1'b1, 8'hAA, 1'b0);
    step(0, 1'b1, 8'hAA, 1'b0);
    step(0, 1'b1, 8'hAB, 1'b1);
    for (int i = 0; i < 7; i++) step(0, 1'b0, 8'h00, 1'b1);
    step(0, 1'b0, 8'h00, 1'b1);
    step(0, 1'b0, 8'h00, 1'b1);
    step(0, 1'b1, 8'h55, 1'b1);
    step(0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 1'b1, 8'(8'h20 + i), 1'b0);
    step(0, 1'b1, 8'h30, 1'b1);
    step(0, 1'b0, 8'h00, 1'b0);
    rand_run(0, 300);

    // FWFT fall-through and pop on the depth-5 FIFO.
    while (mq[1].size() > 0) step(1, 1'b0, 8'h00, 1'b1);
    step(1, 1'b1, 8'h3C, 1'b0);
    step(1, 1'b0, 8'h00, 1'b0);
    step(1, 1'b0, 8'h00, 1'b1);
    step(1, 1'b1, 8'h3D, 1'b0);
    step(1, 1'b0, 8'h00, 1'b0);
    step(1, 1'b1, 8'h3E, 1'b1);
    step(1, 1'b0, 8'h00, 1'b1);
    step(1, 1'b0, 8'h00, 1'b1);
    rand_run(1, 400);

    // Reset in the middle of traffic, then new data must come out, not stale entries.
    while (mq[0].size() > 0) step(0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(0, 1'b1, 8'(8'hC0 + i), 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset(0);
    chk_reset(1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    step(0, 1'b1, 8'h77, 1'b0);
    step(0, 1'b0, 8'h00, 1'b1);
    step(0, 1'b0, 8'h00, 1'b0);
    step(1, 1'b1, 8'h88, 1'b0);
    step(1, 1'b0, 8'h00, 1'b0);
    step(1, 1'b0, 8'h00, 1'b1);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
